adventure_input_ctrl: RTL and testbench
=======================================

# adventure_input_ctrl

Front-end input stage for the adventure game FSM. It takes five raw, asynchronous, bouncing active-high pushbuttons (four compass directions plus start), synchronises and debounces them, and encodes direction presses into the held 2-bit `direction` code. It also produces the latched `start` level that the game FSM consumes, plus a one-cycle press strobe and a saturating move counter for the display and debug logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required to accept a level change. Legal range is 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the debounce counter. Derived; never overridden.

Ports:
- `clk`  in  1: the single clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserts on the falling edge of `reset` with no clock; releases synchronously to `clk`).
- `btn_n`, `btn_s`, `btn_e`, `btn_w`  in  1 each: raw direction buttons, active-high, asynchronous.
- `btn_start`  in  1: raw start button, active-high, asynchronous.
- `direction`  out  2: last accepted direction code (N=2'b00, S=2'b01, E=2'b10, W=2'b11). Held between presses.
- `dir_valid`  out  1: one-cycle strobe in the cycle `direction` takes a newly accepted press.
- `start`  out  1: goes high on the first accepted start press and stays high until reset.
- `moves`  out  8: count of accepted direction presses; saturates at 255.

## Operation
- Synchroniser: two flops per button; only the second-stage output is used downstream.
- Debouncer, one per button:
  - Holds state `db` and counter `cnt`.
  - If sync ≠ `db`, `cnt` increments. On the cycle `cnt` would reach `DEBOUNCE_CYCLES`, `db` flips and `cnt` clears.
  - If sync = `db`, `cnt` clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `db`.
- Rising-edge detect on each `db`: `rise = db & ~db_d`.
- Direction register:
  - On any direction `rise`, `direction` loads the code of the winning button, `dir_valid` pulses, and `moves` increments unless it is already 255.
  - Simultaneous rises are resolved by fixed priority N > S > E > W. Exactly one press is accepted, one pulse is issued, and `moves` advances by 1.
  - A held button produces one press only. Release produces nothing.
- Direction presses are accepted regardless of `start`. The game FSM samples `direction` as a level.
- Start: a `rise` on the start debouncer sets `start`, which is sticky. Further presses have no effect.
- Reset (any time, including mid-debounce or mid-strobe) immediately forces every output to its reset value:
  - sync flops, `db`, `db_d` and all `cnt` = 0
  - `direction` = 2'b00, `dir_valid` = 0, `start` = 0, `moves` = 0
- Buttons already held across reset release are seen as new presses after the full debounce latency.

## Timing
- Latency: the raw button is first sampled high at edge k. Then `db` sets at edge k+1+`DEBOUNCE_CYCLES`, and `direction`/`dir_valid`/`start` update at edge k+2+`DEBOUNCE_CYCLES`. With the default of 16, that is 18 edges after sampling.
- `dir_valid` is high for exactly one cycle per accepted press.
- Minimum spacing between two accepted presses of the same button: 2×`DEBOUNCE_CYCLES` (+2 sync edges for each transition).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `adventure_pkg` holds:
  - direction localparams `DIR_N`, `DIR_S`, `DIR_E`, `DIR_W`
  - `ROOM_W` = 3
  - `DEBOUNCE_DEFAULT` = 16

  The game FSM imports the same package.
- Sub-module `button_debounce`: parameterised by `DEBOUNCE_CYCLES`. It contains the 2-flop synchroniser, counter and `db` register, with ports `clk`, `reset`, `raw`, `db`. The top instantiates five copies and adds edge detect, priority encoder, start latch and move counter.

## Test plan
- Clean N press held 40 cycles after reset → `dir_valid` pulses once at edge k+18, `direction`=2'b00, `moves`=1; release produces no pulse.
- E press bouncing (toggling every 3 cycles for 12 cycles, then stable high 30 cycles) → exactly one `dir_valid`, `direction`=2'b10. A 10-cycle W glitch alone → no change.
- S and W rise in the same cycle → `direction`=2'b01, one pulse, `moves` +1.
- `btn_start` pressed twice, 100 cycles apart → `start` 0→1 at edge k+18 and stays 1. `direction`/`moves` are unaffected.
- 260 alternating N/W presses → `moves` saturates at 255; the final `direction` matches the last press.
- Assert `reset` low mid-debounce (cnt=10) and again during a `dir_valid` cycle → all outputs drop to reset values in the same cycle with no clock edge; a held button re-accepts 18 edges after reset release.

Source files
------------

// File: rtl/adventure_pkg.sv
// Shared definitions for the adventure game input stage and game FSM.
// Direction codes, room width and button indexing live here.
package adventure_pkg;

    localparam logic [1:0] DIR_N = 2'b00;
    localparam logic [1:0] DIR_S = 2'b01;
    localparam logic [1:0] DIR_E = 2'b10;
    localparam logic [1:0] DIR_W = 2'b11;

    localparam int ROOM_W           = 3;
    localparam int DEBOUNCE_DEFAULT = 16;

    localparam int NUM_BTN   = 5;
    localparam int BTN_N     = 0;
    localparam int BTN_S     = 1;
    localparam int BTN_E     = 2;
    localparam int BTN_W     = 3;
    localparam int BTN_START = 4;

    localparam logic [7:0] MOVES_MAX = 8'hFF;

    // Fixed priority N > S > E > W over simultaneous rises.
    function automatic logic [1:0] dir_encode(input logic [3:0] rise);
        logic [1:0] code;
        code = DIR_N;
        if (rise[BTN_N]) begin
            code = DIR_N;
        end else if (rise[BTN_S]) begin
            code = DIR_S;
        end else if (rise[BTN_E]) begin
            code = DIR_E;
        end else if (rise[BTN_W]) begin
            code = DIR_W;
        end
        return code;
    endfunction

endpackage

// File: rtl/adventure_input_ctrl_debounce.sv
// One pushbutton: two-flop synchroniser followed by a stable-count
// debouncer that only accepts a level held for DEBOUNCE_CYCLES cycles.
module button_debounce
    import adventure_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-stage synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Count cycles of disagreement; flip db when the run is long enough.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level and its run counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/adventure_input_ctrl.sv
// Input front end: debounces five buttons, encodes direction presses,
// latches start and counts accepted moves (saturating).
module adventure_input_ctrl
    import adventure_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       btn_s,
    input  logic       btn_e,
    input  logic       btn_w,
    input  logic       btn_start,
    output logic [1:0] direction,
    output logic       dir_valid,
    output logic       start,
    output logic [7:0] moves
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] db;
    logic [NUM_BTN-1:0] db_d_q;
    logic [NUM_BTN-1:0] rise;

    logic [1:0] direction_q;
    logic [1:0] direction_d;
    logic       dir_valid_q;
    logic       dir_valid_d;
    logic       start_q;
    logic       start_d;
    logic [7:0] moves_q;
    logic [7:0] moves_d;

    assign raw[BTN_N]     = btn_n;
    assign raw[BTN_S]     = btn_s;
    assign raw[BTN_E]     = btn_e;
    assign raw[BTN_W]     = btn_w;
    assign raw[BTN_START] = btn_start;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .db   (db[i])
        );
    end

    // Delayed copy of the debounced levels for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_d_q <= '0;
        end else begin
            db_d_q <= db;
        end
    end

    assign rise = db & ~db_d_q;

    // Next-state for direction, strobe, sticky start and move counter.
    always_comb begin
        direction_d = direction_q;
        dir_valid_d = 1'b0;
        moves_d     = moves_q;
        start_d     = start_q | rise[BTN_START];
        if (|rise[BTN_W:BTN_N]) begin
            direction_d = dir_encode(rise[BTN_W:BTN_N]);
            dir_valid_d = 1'b1;
            if (moves_q != MOVES_MAX) begin
                moves_d = moves_q + 8'd1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            direction_q <= DIR_N;
            dir_valid_q <= 1'b0;
            start_q     <= 1'b0;
            moves_q     <= 8'd0;
        end else begin
            direction_q <= direction_d;
            dir_valid_q <= dir_valid_d;
            start_q     <= start_d;
            moves_q     <= moves_d;
        end
    end

    assign direction = direction_q;
    assign dir_valid = dir_valid_q;
    assign start     = start_q;
    assign moves     = moves_q;

endmodule

// File: tb/tb_adventure_input_ctrl.sv
// Self-checking bench for adventure_input_ctrl with a history-window
// reference model and directed literal checks.
module tb_adventure_input_ctrl;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b0;
    logic       btn_s = 1'b0;
    logic       btn_e = 1'b0;
    logic       btn_w = 1'b0;
    logic       btn_start = 1'b0;
    logic [1:0] direction;
    logic       dir_valid;
    logic       start;
    logic [7:0] moves;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adventure_input_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .btn_n    (btn_n),
        .btn_s    (btn_s),
        .btn_e    (btn_e),
        .btn_w    (btn_w),
        .btn_start(btn_start),
        .direction(direction),
        .dir_valid(dir_valid),
        .start    (start),
        .moves    (moves)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronised
    // samples all disagree with the currently accepted level.
    logic [4:0] raw_v;
    assign raw_v = {btn_start, btn_w, btn_e, btn_s, btn_n};

    bit m_s1[5];
    bit m_s2[5];
    bit m_db[5];
    bit m_dbd[5];
    bit hist[5][D];
    bit [4:0] m_rise;
    int m_dir = 0;
    int m_moves = 0;
    bit m_valid = 0;
    bit m_start = 0;

    always @(posedge clk or negedge reset) begin : model
        bit alld;
        if (!reset) begin
            for (int b = 0; b < 5; b++) begin
                m_s1[b] = 0;
                m_s2[b] = 0;
                m_db[b] = 0;
                m_dbd[b] = 0;
                for (int i = 0; i < D; i++) hist[b][i] = 0;
            end
            m_dir = 0;
            m_moves = 0;
            m_valid = 0;
            m_start = 0;
        end else begin
            for (int b = 0; b < 5; b++) begin
                m_rise[b] = m_db[b] & ~m_dbd[b];
                m_dbd[b] = m_db[b];
                for (int i = D - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = m_s2[b];
                alld = 1;
                for (int i = 0; i < D; i++)
                    if (hist[b][i] == m_db[b]) alld = 0;
                if (alld) m_db[b] = ~m_db[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = raw_v[b];
            end
            m_valid = (m_rise[3:0] != 0);
            for (int b = 3; b >= 0; b--)
                if (m_rise[b]) m_dir = b;
            if (m_valid && m_moves < 255) m_moves = m_moves + 1;
            if (m_rise[4]) m_start = 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmp_direction", direction, m_dir);
        chk("cmp_dir_valid", dir_valid, m_valid);
        chk("cmp_start", start, m_start);
        chk("cmp_moves", moves, m_moves);
    end

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poss(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        negs(3);
        chk("rst_direction", direction, 0);
        chk("rst_dir_valid", dir_valid, 0);
        chk("rst_start", start, 0);
        chk("rst_moves", moves, 0);
        reset = 1'b1;
        negs(3);

        // Clean N press held 40 cycles.
        btn_n = 1'b1;
        poss(18);
        chk("n_not_yet", dir_valid, 0);
        poss(1);
        chk("n_valid", dir_valid, 1);
        chk("n_direction", direction, 0);
        chk("n_moves", moves, 1);
        poss(1);
        chk("n_single_pulse", dir_valid, 0);
        negs(20);
        btn_n = 1'b0;
        negs(40);
        chk("n_release_moves", moves, 1);

        // Bouncing E press.
        for (int t = 0; t < 4; t++) begin
            btn_e = (t % 2 == 0);
            negs(3);
        end
        btn_e = 1'b1;
        negs(30);
        btn_e = 1'b0;
        negs(40);
        chk("e_moves", moves, 2);
        chk("e_direction", direction, 2);

        // Short W glitch is filtered.
        btn_w = 1'b1;
        negs(10);
        btn_w = 1'b0;
        negs(40);
        chk("w_glitch_moves", moves, 2);
        chk("w_glitch_direction", direction, 2);

        // Simultaneous S and W.
        btn_s = 1'b1;
        btn_w = 1'b1;
        poss(19);
        chk("sw_valid", dir_valid, 1);
        chk("sw_direction", direction, 1);
        chk("sw_moves", moves, 3);
        negs(20);
        btn_s = 1'b0;
        btn_w = 1'b0;
        negs(40);
        chk("sw_moves_after", moves, 3);

        // Start pressed twice.
        btn_start = 1'b1;
        poss(18);
        chk("start_not_yet", start, 0);
        poss(1);
        chk("start_set", start, 1);
        negs(11);
        btn_start = 1'b0;
        negs(70);
        btn_start = 1'b1;
        negs(30);
        btn_start = 1'b0;
        negs(40);
        chk("start_sticky", start, 1);
        chk("start_moves", moves, 3);
        chk("start_direction", direction, 1);

        // 260 alternating N/W presses saturate the counter.
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) btn_n = 1'b1;
            else btn_w = 1'b1;
            negs(20);
            btn_n = 1'b0;
            btn_w = 1'b0;
            negs(20);
        end
        chk("sat_moves", moves, 255);
        chk("sat_direction", direction, 3);

        // Reset mid-debounce with N held.
        btn_n = 1'b1;
        poss(12);
        #2 reset = 1'b0;
        #1;
        chk("rst1_direction", direction, 0);
        chk("rst1_dir_valid", dir_valid, 0);
        chk("rst1_start", start, 0);
        chk("rst1_moves", moves, 0);
        negs(2);
        reset = 1'b1;
        poss(18);
        chk("rel1_not_yet", dir_valid, 0);
        poss(1);
        chk("rel1_valid", dir_valid, 1);
        chk("rel1_moves", moves, 1);

        // Reset during the dir_valid cycle.
        #2 reset = 1'b0;
        #1;
        chk("rst2_dir_valid", dir_valid, 0);
        chk("rst2_moves", moves, 0);
        @(negedge clk);
        reset = 1'b1;
        poss(19);
        chk("rel2_valid", dir_valid, 1);
        chk("rel2_moves", moves, 1);
        chk("rel2_direction", direction, 0);
        @(negedge clk);
        btn_n = 1'b0;
        negs(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
